register_ctr: RTL
=================

// Module: register_ctr
// PURPOSE
//   Parametrised counting register for the 6502 datapath (PC, SP, index/address temporaries).
//   Extends a plain load register with byte-lane loads from the 8-bit data bus,
//   increment/decrement, a registered wrap pulse, a zero flag and a byte-selectable bus output.
//   Sits between the internal data bus and the address/ALU paths; controlled by the decoder.
// PARAMETERS
//   WIDTH      16     register width; legal values 8 or 16 (elaboration error otherwise)
//   RESET_VAL  '0     value loaded on reset (WIDTH bits)
// PORTS
//   clk            in   1      clock, all state updates on rising edge
//   rst_n          in   1      asynchronous, active-low reset
//   data_in        in   8      byte from internal data bus
//   full_in        in   WIDTH  full-width load value (address path)
//   load_full      in   1      load full_in
//   load_lo        in   1      load data_in into bits [7:0]
//   load_hi        in   1      load data_in into bits [15:8] (ignored when WIDTH=8)
//   inc            in   1      increment by 1, modulo 2^WIDTH
//   dec            in   1      decrement by 1, modulo 2^WIDTH
//   output_enable  in   1      gates data_out and bus_out
//   sel_hi         in   1      bus_out byte select (0 = [7:0], 1 = [15:8]; forced 0 when WIDTH=8)
//   data_out       out  WIDTH  stored value when output_enable, else 0
//   bus_out        out  8      selected byte when output_enable, else 0
//   zero           out  1      stored value == 0 (combinational from state, ungated)
//   wrap           out  1      one-cycle pulse: previous cycle's inc/dec wrapped
// BEHAVIOUR
//   - Reset (async, rst_n=0): value <= RESET_VAL, wrap <= 0; outputs follow combinationally.
//   - Per-edge priority: load_full > (load_lo | load_hi) > inc/dec > hold.
//   - load_lo and load_hi together: both bytes written from data_in in one cycle.
//   - Any load suppresses inc/dec in the same cycle; wrap <= 0 on load cycles.
//   - inc and dec both high (no load): hold, wrap <= 0.
//   - inc at all-ones -> 0, wrap <= 1; dec at 0 -> all-ones, wrap <= 1; else wrap <= 0.
//   - Latency: new value visible on data_out/bus_out/zero one cycle after the strobe edge.
//   - No carry between byte lanes on byte loads; inc/dec carry through full WIDTH.
//   - Reset asserted mid-operation discards any pending strobe; first post-reset edge obeys inputs.
// CONFIGURATION
//   REGISTER_CTR_SHADOW_EN defined: adds ports save (in,1) and restore (in,1) and a
//     WIDTH-bit shadow register (reset RESET_VAL). save copies the value at the edge
//     (pre-update value if other strobes are also active). restore loads shadow with
//     priority above load_full; wrap <= 0. save+restore together: swap value and shadow.
//   Not defined: no shadow state, no save/restore ports; behaviour otherwise identical.
// STRUCTURE
//   register_pkg: typedef enum logic [1:0] ctr_op_e {OP_HOLD, OP_LOAD, OP_INC, OP_DEC};
//     localparam BYTE_W = 8.
//   Sub-module ctr_op_decode: strobes -> ctr_op_e plus byte-lane write mask (pure combinational).
//   Top: state register, next-value mux, wrap register, output gating.
// TESTING
//   1. Reset with RESET_VAL=16'hFFFC -> data_out=16'hFFFC (oe=1), wrap=0, zero=0.
//   2. load_lo data_in=8'h34, then load_hi data_in=8'h12 -> 16'h1234; sel_hi=1 -> bus_out=8'h12.
//   3. value 16'hFFFF, inc -> 16'h0000 next cycle, wrap=1 for exactly one cycle, zero=1.
//   4. value 16'h0000, dec+load_lo data_in=8'h55 -> 16'h0055, wrap=0 (load wins).
//   5. inc+dec together at 16'h00FF -> holds 16'h00FF; output_enable=0 -> data_out=0, bus_out=0.
//   6. SHADOW_EN: value 16'hC000, save; load_full 16'h1234; restore -> 16'hC000.

Source files
------------

// File: rtl/register_pkg.sv
// Shared types for the counting register: operation encoding and lane width.
package register_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } ctr_op_e;
endpackage

// File: rtl/ctr_op_decode.sv
// Strobe decoder for register_ctr: picks one operation per edge plus the byte-lane write mask.
module ctr_op_decode
    import register_pkg::*;
#(
    parameter bit HAS_HI = 1'b1
) (
    input  logic       load_full,
    input  logic       load_lo,
    input  logic       load_hi,
    input  logic       inc,
    input  logic       dec,
    output ctr_op_e    op,
    output logic       use_full,
    output logic [1:0] lane_we
);
    logic hi_req;

    // A narrow register has no high lane, so load_hi must not block inc/dec.
    assign hi_req = load_hi & HAS_HI;

    always_comb begin
        op       = OP_HOLD;
        use_full = 1'b0;
        lane_we  = 2'b00;
        if (load_full) begin
            op       = OP_LOAD;
            use_full = 1'b1;
            lane_we  = 2'b11;
        end else if (load_lo || hi_req) begin
            op      = OP_LOAD;
            lane_we = {hi_req, load_lo};
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end
    end
endmodule

// File: rtl/register_ctr.sv
// Counting register with byte-lane loads, inc/dec, wrap pulse, zero flag and gated bus output.
// Optional shadow register with save/restore when REGISTER_CTR_SHADOW_EN is defined.
module register_ctr
    import register_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic [WIDTH-1:0] full_in,
    input  logic             load_full,
    input  logic             load_lo,
    input  logic             load_hi,
    input  logic             inc,
    input  logic             dec,
`ifdef REGISTER_CTR_SHADOW_EN
    input  logic             save,
    input  logic             restore,
`endif
    input  logic             output_enable,
    input  logic             sel_hi,
    output logic [WIDTH-1:0] data_out,
    output logic [7:0]       bus_out,
    output logic             zero,
    output logic             wrap
);
    if ((WIDTH != 8) && (WIDTH != 16)) begin : g_width_check
        $error("register_ctr: WIDTH must be 8 or 16");
    end

    ctr_op_e          op;
    logic             use_full;
    logic [1:0]       lane_we;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] value_next;
    logic             wrap_next;

    ctr_op_decode #(
        .HAS_HI (WIDTH == 16)
    ) u_decode (
        .load_full (load_full),
        .load_lo   (load_lo),
        .load_hi   (load_hi),
        .inc       (inc),
        .dec       (dec),
        .op        (op),
        .use_full  (use_full),
        .lane_we   (lane_we)
    );

`ifdef REGISTER_CTR_SHADOW_EN
    logic [WIDTH-1:0] shadow;
`endif

    always_comb begin
        value_next = value;
        wrap_next  = 1'b0;
        case (op)
            OP_LOAD: begin
                if (use_full) begin
                    value_next = full_in;
                end else begin
                    if (lane_we[0]) value_next[BYTE_W-1:0] = data_in;
                    // Only reachable for WIDTH=16, where this slice is the high byte.
                    if (lane_we[1]) value_next[WIDTH-1 -: BYTE_W] = data_in;
                end
            end
            OP_INC: begin
                value_next = value + WIDTH'(1);
                wrap_next  = &value;
            end
            OP_DEC: begin
                value_next = value - WIDTH'(1);
                wrap_next  = ~|value;
            end
            default: begin
                value_next = value;
            end
        endcase
`ifdef REGISTER_CTR_SHADOW_EN
        if (restore) begin
            value_next = shadow;
            wrap_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VAL;
            wrap  <= 1'b0;
        end else begin
            value <= value_next;
            wrap  <= wrap_next;
        end
    end

`ifdef REGISTER_CTR_SHADOW_EN
    // Captures the pre-update value, so save+restore swaps the two registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= RESET_VAL;
        end else if (save) begin
            shadow <= value;
        end
    end
`endif

    assign zero     = (value == '0);
    assign data_out = output_enable ? value : '0;
    assign bus_out  = !output_enable ? 8'h00 :
                      ((WIDTH == 16) && sel_hi) ? value[WIDTH-1 -: BYTE_W] :
                      value[BYTE_W-1:0];
endmodule
